// File: rtl/sr_flag_pkg.sv
// Shared definitions for the SR flag arbiter: command op encodings and
// default parameter values used by the top level and its arbiter.
package sr_flag_pkg;

  typedef enum logic [1:0] {
    OP_HOLD = 2'b00,
    OP_CLR  = 2'b01,
    OP_SET  = 2'b10,
    OP_INV  = 2'b11
  } flag_op_e;

  localparam int DEF_NUM_REQ   = 4;
  localparam int DEF_NUM_FLAGS = 8;
  localparam int DEF_IDX_W     = 3;
  localparam int DEF_CNT_W     = 8;

endpackage

// File: rtl/sr_flag_arbiter_rr_arbiter.sv
// Round-robin arbiter with a wrap-around priority scan.
// Ports:
//   clk, reset : clock (rising edge), asynchronous active-high reset
//   req[N]     : request vector (already masked by the caller)
//   advance    : a grant was accepted this cycle; move the pointer past it
//   gnt[N]     : one-hot combinational grant, zero when nothing requests
module rr_arbiter
  import sr_flag_pkg::*;
#(
  parameter int N = DEF_NUM_REQ
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] gnt
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] next_ptr;
  logic [PW-1:0] j;
  logic          found;

  // Scan from rr_ptr upward, wrapping modulo N; the first requester wins
  // and the pointer moves to the slot just after it.
  always_comb begin
    gnt      = '0;
    next_ptr = rr_ptr;
    j        = '0;
    found    = 1'b0;
    for (int k = 0; k < N; k++) begin
      j = PW'((int'(rr_ptr) + k) % N);
      if (!found && req[j]) begin
        gnt[j]   = 1'b1;
        found    = 1'b1;
        next_ptr = (j == PW'(N - 1)) ? '0 : j + 1'b1;
      end
    end
  end

  // Pointer register: only moves when a grant is actually taken.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (advance) begin
      rr_ptr <= next_ptr;
    end
  end

endmodule

// File: rtl/sr_flag_arbiter.sv
// Shared bank of SR status flags written by several requesters through a
// round-robin arbitrated valid/ready handshake.
// Ports:
//   clk, reset  : clock (rising edge), asynchronous active-high reset
//   req_valid   : per-requester command valid
//   req_op      : per-requester op, 2 bits each (hold/clear/set/invalid)
//   req_idx     : per-requester flag index, IDX_W bits each
//   req_ready   : one-hot combinational grant
//   clear_all   : synchronous bank clear, blocks all grants while high
//   flags       : flag bank (q), flags_bar its complement (q_bar)
//   err_cnt     : saturating count of accepted invalid/out-of-range commands
//   grant_id    : index of the last granted requester
module sr_flag_arbiter
  import sr_flag_pkg::*;
#(
  parameter int NUM_REQ   = DEF_NUM_REQ,
  parameter int NUM_FLAGS = DEF_NUM_FLAGS,
  parameter int IDX_W     = DEF_IDX_W,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [2*NUM_REQ-1:0]     req_op,
  input  logic [IDX_W*NUM_REQ-1:0] req_idx,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic                     clear_all,
  output logic [NUM_FLAGS-1:0]     flags,
  output logic [NUM_FLAGS-1:0]     flags_bar,
  output logic [CNT_W-1:0]         err_cnt,
  output logic [IDX_W-1:0]         grant_id
);

  localparam logic [IDX_W:0] NF = (IDX_W + 1)'(NUM_FLAGS);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  logic [NUM_REQ-1:0]   arb_req;
  logic [NUM_REQ-1:0]   gnt;
  logic                 xfer;
  flag_op_e             sel_op;
  logic [IDX_W-1:0]     sel_idx;
  logic [IDX_W-1:0]     sel_id;
  logic                 in_range;
  logic                 bad_cmd;
  logic [NUM_FLAGS-1:0] mask;

  logic [NUM_FLAGS-1:0] flag_bank_p1;
  logic [CNT_W-1:0]     err_cnt_p1;
  logic [IDX_W-1:0]     grant_id_p1;

  // clear_all hides every request from the arbiter so pending commands
  // simply wait; reset additionally forces ready low at the output.
  assign arb_req = req_valid & {NUM_REQ{~clear_all}};

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (arb_req),
    .advance (xfer),
    .gnt     (gnt)
  );

  assign req_ready = gnt & {NUM_REQ{~reset}};
  assign xfer      = |(req_valid & req_ready);

  always_comb begin
    sel_op  = OP_HOLD;
    sel_idx = '0;
    sel_id  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        sel_op  = flag_op_e'(req_op[2*i +: 2]);
        sel_idx = req_idx[IDX_W*i +: IDX_W];
        sel_id  = IDX_W'(i);
      end
    end
  end

  assign in_range = ({1'b0, sel_idx} < NF);
  assign bad_cmd  = xfer && ((sel_op == OP_INV) || !in_range);
  assign mask     = {{(NUM_FLAGS-1){1'b0}}, 1'b1} << sel_idx;

  // ---- stage p1: flag bank, error counter and grant id registers ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flag_bank_p1 <= '0;
    end else if (clear_all) begin
      flag_bank_p1 <= '0;
    end else if (xfer && in_range) begin
      case (sel_op)
        OP_SET:  flag_bank_p1 <= flag_bank_p1 | mask;
        OP_CLR:  flag_bank_p1 <= flag_bank_p1 & ~mask;
        default: flag_bank_p1 <= flag_bank_p1;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_cnt_p1 <= '0;
    end else if (bad_cmd) begin
      err_cnt_p1 <= sat_inc(err_cnt_p1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant_id_p1 <= '0;
    end else if (xfer) begin
      grant_id_p1 <= sel_id;
    end
  end

  assign flags     = flag_bank_p1;
  assign flags_bar = ~flag_bank_p1;
  assign err_cnt   = err_cnt_p1;
  assign grant_id  = grant_id_p1;

endmodule

// File: tb/tb_sr_flag_arbiter.sv
// Self-checking bench for sr_flag_arbiter. The main instance uses the
// default 4 requesters x 8 flags; a 3-bit index cannot name flag 9, so a
// second 2-requester x 6-flag instance covers out-of-range indices.
module tb_sr_flag_arbiter;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [7:0]  req_op = '0;
  logic [11:0] req_idx = '0;
  logic        clear_all = 1'b0;
  logic [3:0]  req_ready;
  logic [7:0]  flags, flags_bar, err_cnt;
  logic [2:0]  grant_id;

  logic [1:0]  b_valid = '0;
  logic [3:0]  b_op = '0;
  logic [5:0]  b_idx = '0;
  logic [1:0]  b_ready;
  logic [5:0]  b_flags, b_flags_bar;
  logic [7:0]  b_err;
  logic [2:0]  b_gid;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [7:0] m_flags = '0;
  int m_err = 0;
  int m_ptr = 0;
  int m_gid = 0;

  sr_flag_arbiter dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_op(req_op),
    .req_idx(req_idx), .req_ready(req_ready), .clear_all(clear_all),
    .flags(flags), .flags_bar(flags_bar), .err_cnt(err_cnt), .grant_id(grant_id)
  );

  sr_flag_arbiter #(.NUM_REQ(2), .NUM_FLAGS(6), .IDX_W(3), .CNT_W(8)) dut_b (
    .clk(clk), .reset(reset), .req_valid(b_valid), .req_op(b_op),
    .req_idx(b_idx), .req_ready(b_ready), .clear_all(1'b0),
    .flags(b_flags), .flags_bar(b_flags_bar), .err_cnt(b_err), .grant_id(b_gid)
  );

  always #5 clk = ~clk;

  // Winner under the spec rule: first valid requester at or after the
  // pointer, wrapping; nobody wins during reset or clear_all.
  function automatic int model_grant();
    if (reset || clear_all) return -1;
    for (int k = 0; k < N; k++) begin
      if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [3:0] exp_ready();
    int g;
    logic [3:0] r;
    g = model_grant();
    r = '0;
    if (g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  task automatic set_req(input int i, input logic v, input logic [1:0] op, input logic [2:0] idx);
    req_valid[i]       = v;
    req_op[2*i +: 2]   = op;
    req_idx[3*i +: 3]  = idx;
  endtask

  // Advance one clock and apply the spec's update rules to the model.
  task automatic step();
    int g, idx;
    logic [1:0] op;
    g = model_grant();
    @(posedge clk);
    if (reset) begin
      m_flags = '0; m_err = 0; m_ptr = 0; m_gid = 0;
    end else if (clear_all) begin
      m_flags = '0;
    end else if (g >= 0) begin
      op  = req_op[2*g +: 2];
      idx = int'(req_idx[3*g +: 3]);
      if (op == 2'b11 || idx >= 8) begin
        if (m_err < 255) m_err++;
      end else if (op == 2'b10) m_flags[idx] = 1'b1;
      else if (op == 2'b01) m_flags[idx] = 1'b0;
      m_ptr = (g + 1) % N;
      m_gid = g;
    end
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    req_valid = '0; req_op = '0; req_idx = '0; clear_all = 1'b0;
    b_valid = '0; b_op = '0; b_idx = '0;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req_valid = 4'hF; req_op = 8'hAA; req_idx = 12'h0D1;
    step();
    step();
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready actual=%b expected=0000", req_ready); end
    checks++; if (flags !== 8'h00) begin errors++; $display("FAIL reset_flags actual=%h expected=00", flags); end
    checks++; if (flags_bar !== 8'hFF) begin errors++; $display("FAIL reset_flags_bar actual=%h expected=ff", flags_bar); end
    checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL reset_err actual=%0d expected=0", err_cnt); end
    checks++; if (grant_id !== 3'd0) begin errors++; $display("FAIL reset_gid actual=%0d expected=0", grant_id); end
    reset = 1'b0;
    req_valid = '0; req_op = '0; req_idx = '0;
    #1;
  endtask

  task automatic test_set_clear();
    set_req(0, 1'b1, 2'b10, 3'd3);
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL set_ready actual=%b expected=0001", req_ready); end
    step();
    checks++; if (flags !== 8'h08) begin errors++; $display("FAIL set_flags actual=%h expected=08", flags); end
    set_req(0, 1'b1, 2'b01, 3'd3);
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL clr_ready actual=%b expected=0001", req_ready); end
    step();
    checks++; if (flags !== 8'h00) begin errors++; $display("FAIL clr_flags actual=%h expected=00", flags); end
    checks++; if (flags_bar !== 8'hFF) begin errors++; $display("FAIL clr_flags_bar actual=%h expected=ff", flags_bar); end
    req_valid = '0;
  endtask

  task automatic test_round_robin();
    logic [3:0] exp;
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 2'b10, 3'(i));
    for (int k = 0; k < N; k++) begin
      #1;
      exp = '0; exp[k] = 1'b1;
      checks++; if (req_ready !== exp) begin errors++; $display("FAIL rr_ready%0d actual=%b expected=%b", k, req_ready, exp); end
      step();
      checks++; if (grant_id !== 3'(k)) begin errors++; $display("FAIL rr_gid%0d actual=%0d expected=%0d", k, grant_id, k); end
      req_valid[k] = 1'b0;
    end
    checks++; if (flags !== 8'h0F) begin errors++; $display("FAIL rr_flags actual=%h expected=0f", flags); end
  endtask

  task automatic test_wrap();
    set_req(2, 1'b1, 2'b00, 3'd0);
    step();
    req_valid = '0;
    set_req(1, 1'b1, 2'b00, 3'd0);
    set_req(3, 1'b1, 2'b00, 3'd0);
    #1;
    checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL wrap_first actual=%b expected=1000", req_ready); end
    step();
    req_valid[3] = 1'b0;
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL wrap_second actual=%b expected=0010", req_ready); end
    step();
    checks++; if (grant_id !== 3'd1) begin errors++; $display("FAIL wrap_gid actual=%0d expected=1", grant_id); end
    checks++; if (flags !== 8'h0F) begin errors++; $display("FAIL wrap_hold_flags actual=%h expected=0f", flags); end
    req_valid = '0;
  endtask

  task automatic test_conflict();
    do_reset();
    set_req(0, 1'b1, 2'b10, 3'd5);
    set_req(1, 1'b1, 2'b01, 3'd5);
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL conf_ready0 actual=%b expected=0001", req_ready); end
    step();
    checks++; if (flags[5] !== 1'b1) begin errors++; $display("FAIL conf_set actual=%b expected=1", flags[5]); end
    req_valid[0] = 1'b0;
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL conf_ready1 actual=%b expected=0010", req_ready); end
    step();
    checks++; if (flags[5] !== 1'b0) begin errors++; $display("FAIL conf_clr actual=%b expected=0", flags[5]); end
    req_valid = '0;
  endtask

  task automatic test_errors();
    do_reset();
    set_req(0, 1'b1, 2'b11, 3'd2);
    step();
    req_valid = '0;
    checks++; if (err_cnt !== 8'd1) begin errors++; $display("FAIL inv_err actual=%0d expected=1", err_cnt); end
    checks++; if (flags !== 8'h00) begin errors++; $display("FAIL inv_flags actual=%h expected=00", flags); end
    // out-of-range on the 6-flag instance
    b_valid = 2'b01; b_op = 4'b0011; b_idx = 6'd2;
    #1;
    checks++; if (b_ready !== 2'b01) begin errors++; $display("FAIL b_ready actual=%b expected=01", b_ready); end
    step();
    checks++; if (b_err !== 8'd1) begin errors++; $display("FAIL b_inv_err actual=%0d expected=1", b_err); end
    b_op = 4'b0010; b_idx = 6'd7;
    step();
    checks++; if (b_err !== 8'd2) begin errors++; $display("FAIL b_range_err actual=%0d expected=2", b_err); end
    checks++; if (b_flags !== 6'h00) begin errors++; $display("FAIL b_range_flags actual=%h expected=00", b_flags); end
    b_idx = 6'd5;
    step();
    b_valid = '0;
    checks++; if (b_flags !== 6'h20) begin errors++; $display("FAIL b_set_flags actual=%h expected=20", b_flags); end
    checks++; if (b_flags_bar !== 6'h1F) begin errors++; $display("FAIL b_flags_bar actual=%h expected=1f", b_flags_bar); end
    checks++; if (b_err !== 8'd2) begin errors++; $display("FAIL b_err_hold actual=%0d expected=2", b_err); end
    checks++; if (b_gid !== 3'd0) begin errors++; $display("FAIL b_gid actual=%0d expected=0", b_gid); end
  endtask

  task automatic test_clear_all();
    set_req(0, 1'b1, 2'b10, 3'd1);
    step();
    req_valid = '0;
    checks++; if (flags !== 8'h02) begin errors++; $display("FAIL pre_clear_flags actual=%h expected=02", flags); end
    clear_all = 1'b1;
    set_req(2, 1'b1, 2'b10, 3'd7);
    #1;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL clear_ready actual=%b expected=0000", req_ready); end
    step();
    checks++; if (flags !== 8'h00) begin errors++; $display("FAIL clear_flags actual=%h expected=00", flags); end
    checks++; if (err_cnt !== 8'd1) begin errors++; $display("FAIL clear_err actual=%0d expected=1", err_cnt); end
    clear_all = 1'b0;
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL post_clear_ready actual=%b expected=0100", req_ready); end
    step();
    req_valid = '0;
    checks++; if (flags !== 8'h80) begin errors++; $display("FAIL post_clear_flags actual=%h expected=80", flags); end
    checks++; if (grant_id !== 3'd2) begin errors++; $display("FAIL post_clear_gid actual=%0d expected=2", grant_id); end
  endtask

  task automatic test_saturation();
    do_reset();
    set_req(0, 1'b1, 2'b11, 3'd4);
    for (int k = 0; k < 300; k++) step();
    checks++; if (err_cnt !== 8'd255) begin errors++; $display("FAIL sat_err actual=%0d expected=255", err_cnt); end
    for (int k = 0; k < 5; k++) step();
    checks++; if (err_cnt !== 8'd255) begin errors++; $display("FAIL sat_hold actual=%0d expected=255", err_cnt); end
    req_valid = '0;
  endtask

  task automatic test_random();
    logic [3:0] gmask;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      clear_all = ($urandom_range(0, 9) == 0);
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i]) begin
          if ($urandom_range(0, 1) == 1)
            set_req(i, 1'b1, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)));
        end else if ($urandom_range(0, 19) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      #1;
      gmask = exp_ready();
      checks++; if (req_ready !== gmask) begin errors++; $display("FAIL rnd_ready c=%0d actual=%b expected=%b", c, req_ready, gmask); end
      step();
      checks++; if (flags !== m_flags) begin errors++; $display("FAIL rnd_flags c=%0d actual=%h expected=%h", c, flags, m_flags); end
      checks++; if (flags_bar !== ~m_flags) begin errors++; $display("FAIL rnd_flags_bar c=%0d actual=%h expected=%h", c, flags_bar, ~m_flags); end
      checks++; if (err_cnt !== 8'(m_err)) begin errors++; $display("FAIL rnd_err c=%0d actual=%0d expected=%0d", c, err_cnt, m_err); end
      checks++; if (grant_id !== 3'(m_gid)) begin errors++; $display("FAIL rnd_gid c=%0d actual=%0d expected=%0d", c, grant_id, m_gid); end
      req_valid = req_valid & ~gmask;
    end
    clear_all = 1'b0;
  endtask

  task automatic test_reset_midstream();
    if (m_flags == 8'h00) begin
      set_req(0, 1'b1, 2'b10, 3'd6);
      step();
    end
    req_valid = 4'hF; req_op = 8'hAA;
    reset = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL mid_ready actual=%b expected=0000", req_ready); end
    checks++; if (flags !== 8'h00) begin errors++; $display("FAIL mid_flags actual=%h expected=00", flags); end
    checks++; if (flags_bar !== 8'hFF) begin errors++; $display("FAIL mid_flags_bar actual=%h expected=ff", flags_bar); end
    checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL mid_err actual=%0d expected=0", err_cnt); end
    step();
    reset = 1'b0;
    req_valid = '0;
    step();
    checks++; if (flags !== 8'h00) begin errors++; $display("FAIL mid_after_flags actual=%h expected=00", flags); end
    checks++; if (grant_id !== 3'd0) begin errors++; $display("FAIL mid_after_gid actual=%0d expected=0", grant_id); end
    set_req(3, 1'b1, 2'b10, 3'd0);
    #1;
    checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL mid_new_ready actual=%b expected=1000", req_ready); end
    step();
    req_valid = '0;
    checks++; if (flags !== 8'h01) begin errors++; $display("FAIL mid_new_flags actual=%h expected=01", flags); end
    checks++; if (grant_id !== 3'd3) begin errors++; $display("FAIL mid_new_gid actual=%0d expected=3", grant_id); end
  endtask

  initial begin
    test_reset();
    test_set_clear();
    test_round_robin();
    test_wrap();
    test_conflict();
    test_errors();
    test_clear_all();
    test_saturation();
    test_random();
    test_reset_midstream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
